// File: rtl/rvic_plic.sv
// PLIC-style interrupt controller: per-source edge/level gateways, priority
// arbitration against a threshold, and a claim/complete handshake on a simple bus.
module rvic_plic #(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         be_i,
  input  logic               we_i,
  input  logic               re_i,
  output logic [31:0]        data_o
);

  logic [NUM_SRC-1:0] ie_q, ie_d, ip_q, ip_d, mode_q, mode_d, s_q, s_d, src_q;
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [NUM_SRC-1:0] eligible, set_term, claim_vec, done_vec;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [7:0]         off;
  logic [31:0]        rdata;
  logic               claim_en, complete_en;
  logic               unused_addr;

  assign off         = addr_i[7:0];
  assign unused_addr = ^addr_i[31:8];
  assign claim_en    = re_i && (off == 8'h1C);
  assign complete_en = we_i && (off == 8'h1C) && (|be_i);

  // Strict '>' keeps the lowest ID on a priority tie.
  always_comb begin
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    claim_vec = '0;
    done_vec  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      eligible[k] = ip_q[k] & ie_q[k] & (prio_q[k] > thresh_q);
      if (eligible[k] && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        best_id   = ID_W'(k + 1);
      end
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_vec[k] = claim_en && (best_id == ID_W'(k + 1));
      done_vec[k]  = complete_en && (data_i[ID_W-1:0] == ID_W'(k + 1));
    end
  end

  // A level source being claimed this cycle must not re-pend on the claim edge.
  always_comb begin
    set_term = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      set_term[k] = mode_q[k] ? (src_i[k] & ~src_q[k])
                              : (src_i[k] & ~s_q[k] & ~claim_vec[k]);
    end
  end

  always_comb begin
    ie_d     = ie_q;
    ip_d     = ip_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    s_d      = (s_q | claim_vec) & ~done_vec;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (we_i && be_i[2'((k % 32) / 8)]) begin
        if (off == 8'(4 * (k / 32)))
          ie_d[k] = data_i[5'(k % 32)];
        if (off == 8'h10 + 8'(4 * (k / 32)))
          mode_d[k] = data_i[5'(k % 32)];
      end
      ip_d[k] = set_term[k] | (ip_q[k] & ~claim_vec[k] &
                ~(we_i && be_i[2'((k % 32) / 8)] && data_i[5'(k % 32)] &&
                  (off == 8'h08 + 8'(4 * (k / 32)))));
      if (we_i && be_i[2'(k % 4)] && (off == 8'h40 + 8'(4 * (k / 4))))
        prio_d[k] = data_i[8 * (k % 4) +: PRIO_W];
    end
    if (we_i && be_i[0] && (off == 8'h18))
      thresh_d = data_i[PRIO_W-1:0];
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (off == 8'(4 * (k / 32)))         rdata[5'(k % 32)] = ie_q[k];
      if (off == 8'h08 + 8'(4 * (k / 32))) rdata[5'(k % 32)] = ip_q[k];
      if (off == 8'h10 + 8'(4 * (k / 32))) rdata[5'(k % 32)] = mode_q[k];
      if (off == 8'h40 + 8'(4 * (k / 4)))  rdata[8 * (k % 4) +: PRIO_W] = prio_q[k];
    end
    if (off == 8'h18) rdata[PRIO_W-1:0] = thresh_q;
    if (off == 8'h1C) rdata[ID_W-1:0]   = best_id;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q     <= '0;
      ip_q     <= '0;
      mode_q   <= '0;
      s_q      <= '0;
      src_q    <= '0;
      thresh_q <= '0;
      prio_q   <= '{default: '0};
      irq_o    <= 1'b0;
      irq_id_o <= '0;
      data_o   <= '0;
    end else begin
      ie_q     <= ie_d;
      ip_q     <= ip_d;
      mode_q   <= mode_d;
      s_q      <= s_d;
      src_q    <= src_i;
      thresh_q <= thresh_d;
      prio_q   <= prio_d;
      irq_o    <= |eligible;
      irq_id_o <= best_id;
      data_o   <= rdata;
    end
  end

endmodule
